// File: rtl/aes_encipher_lanes.sv
// AES block encipher datapath with SBOX_LANES external S-box words per cycle.
// Optional `AES_ENC_ABORT_EN adds an abort input that cancels a running operation.
module aes_encipher_lanes #(
   parameter int unsigned SBOX_LANES = 1
) (
   input  logic                      clk,
   input  logic                      reset,
`ifdef AES_ENC_ABORT_EN
   input  logic                      abort,
`endif
   input  logic                      next,
   input  logic [1:0]                keylen,
   input  logic [127:0]              block,
   output logic [3:0]                round_no,
   input  logic [127:0]              round_key,
   output logic [32*SBOX_LANES-1:0]  sbox_word,
   input  logic [32*SBOX_LANES-1:0]  new_sbox_word,
   output logic [127:0]              new_block,
   output logic                      ready,
   output logic                      done
);

   localparam int unsigned SBOX_CYCLES = 4 / SBOX_LANES;
   localparam logic [1:0]  SWORD_LAST  = 2'(SBOX_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} fsm_e;

   fsm_e          fsm_q;
   logic [127:0]  state_q;
   logic [127:0]  block_q;
   logic [1:0]    keylen_q;
   logic [3:0]    round_q;
   logic [1:0]    sword_q;
   logic [127:0]  new_block_q;
   logic          ready_q;
   logic          done_q;

   logic          abort_c;
   logic [3:0]    nr_c;
   logic [127:0]  sr_c;
   logic [127:0]  mc_c;
   logic [127:0]  sub_c;

`ifdef AES_ENC_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_word(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Row r of column c takes the byte from column c+r.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = s;
      return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
              w1[31:24], w2[23:16], w3[15:8], w0[7:0],
              w2[31:24], w3[23:16], w0[15:8], w1[7:0],
              w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
   endfunction

   function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] k);
      case (k)
         2'd0:    return s[127:96];
         2'd1:    return s[95:64];
         2'd2:    return s[63:32];
         default: return s[31:0];
      endcase
   endfunction

   function automatic logic [127:0] put_word(input logic [127:0] s, input logic [1:0] k,
                                             input logic [31:0] w);
      logic [127:0] r;
      r = s;
      case (k)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]  = w;
      endcase
      return r;
   endfunction

   always_comb begin
      case (keylen_q)
         2'b01:   nr_c = 4'd12;
         2'b10:   nr_c = 4'd14;
         default: nr_c = 4'd10;
      endcase
   end

   assign sr_c = shift_rows(state_q);
   assign mc_c = {mix_word(sr_c[127:96]), mix_word(sr_c[95:64]),
                  mix_word(sr_c[63:32]),  mix_word(sr_c[31:0])};

   // Present this cycle's state words to the external S-box and merge the results.
   always_comb begin
      logic [1:0] idx;
      idx       = 2'b00;
      sbox_word = '0;
      sub_c     = state_q;
      if (fsm_q == SBOX) begin
         for (int unsigned i = 0; i < SBOX_LANES; i++) begin
            idx = 2'(32'(sword_q) * SBOX_LANES + i);
            sbox_word[32*(SBOX_LANES-i)-1 -: 32] = get_word(state_q, idx);
            sub_c = put_word(sub_c, idx, new_sbox_word[32*(SBOX_LANES-i)-1 -: 32]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         block_q     <= '0;
         keylen_q    <= '0;
         round_q     <= '0;
         sword_q     <= '0;
         new_block_q <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_c && (fsm_q != IDLE)) begin
            fsm_q       <= IDLE;
            ready_q     <= 1'b1;
            new_block_q <= '0;
            sword_q     <= '0;
         end else begin
            case (fsm_q)
               // The done cycle refuses a start so a held request begins one cycle later.
               IDLE: if (next && !done_q) begin
                  block_q  <= block;
                  keylen_q <= keylen;
                  ready_q  <= 1'b0;
                  round_q  <= '0;
                  fsm_q    <= INIT;
               end
               INIT: begin
                  state_q <= block_q ^ round_key;
                  round_q <= 4'd1;
                  sword_q <= '0;
                  fsm_q   <= SBOX;
               end
               SBOX: begin
                  state_q <= sub_c;
                  sword_q <= sword_q + 2'd1;
                  if (sword_q == SWORD_LAST) fsm_q <= MAIN;
               end
               MAIN: if (round_q == nr_c) begin
                  state_q     <= sr_c ^ round_key;
                  new_block_q <= sr_c ^ round_key;
                  ready_q     <= 1'b1;
                  done_q      <= 1'b1;
                  fsm_q       <= IDLE;
               end else begin
                  state_q <= mc_c ^ round_key;
                  round_q <= round_q + 4'd1;
                  sword_q <= '0;
                  fsm_q   <= SBOX;
               end
               default: fsm_q <= IDLE;
            endcase
         end
      end
   end

   assign round_no  = round_q;
   assign new_block = new_block_q;
   assign ready     = ready_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_encipher_lanes.sv
// Bench for aes_encipher_lanes: three lane widths fed by a behavioural S-box and key schedule,
// checked against the FIPS-197 example vectors.
module tb_aes_encipher_lanes;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic          clk = 1'b0;
   logic          reset;
   logic          nx  [3];
   logic [1:0]    kl  [3];
   logic [127:0]  blk;
   logic [3:0]    rn  [3];
   logic [127:0]  rk  [3];
   logic [127:0]  nb  [3];
   logic          rdy [3];
   logic          dn  [3];
`ifdef AES_ENC_ABORT_EN
   logic          ab  [3];
`endif
   logic [31:0]   sw1, nsw1;
   logic [63:0]   sw2, nsw2;
   logic [127:0]  sw4, nsw4;
   logic [31:0]   kw  [3][60];
   int            n_vec = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX_TBL[2047 - 8*32'(b) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   assign nsw1 = sub_word(sw1);
   assign nsw2 = {sub_word(sw2[63:32]), sub_word(sw2[31:0])};
   assign nsw4 = {sub_word(sw4[127:96]), sub_word(sw4[95:64]), sub_word(sw4[63:32]), sub_word(sw4[31:0])};

   always_comb begin
      for (int s = 0; s < 3; s++) begin
         rk[s] = {kw[s][6'(4*rn[s])],     kw[s][6'(4*rn[s] + 1)],
                  kw[s][6'(4*rn[s] + 2)], kw[s][6'(4*rn[s] + 3)]};
      end
   end

   aes_encipher_lanes #(.SBOX_LANES(1)) u_dut1 (
      .clk(clk), .reset(reset),
`ifdef AES_ENC_ABORT_EN
      .abort(ab[0]),
`endif
      .next(nx[0]), .keylen(kl[0]), .block(blk), .round_no(rn[0]), .round_key(rk[0]),
      .sbox_word(sw1), .new_sbox_word(nsw1), .new_block(nb[0]), .ready(rdy[0]), .done(dn[0]));

   aes_encipher_lanes #(.SBOX_LANES(2)) u_dut2 (
      .clk(clk), .reset(reset),
`ifdef AES_ENC_ABORT_EN
      .abort(ab[1]),
`endif
      .next(nx[1]), .keylen(kl[1]), .block(blk), .round_no(rn[1]), .round_key(rk[1]),
      .sbox_word(sw2), .new_sbox_word(nsw2), .new_block(nb[1]), .ready(rdy[1]), .done(dn[1]));

   aes_encipher_lanes #(.SBOX_LANES(4)) u_dut4 (
      .clk(clk), .reset(reset),
`ifdef AES_ENC_ABORT_EN
      .abort(ab[2]),
`endif
      .next(nx[2]), .keylen(kl[2]), .block(blk), .round_no(rn[2]), .round_key(rk[2]),
      .sbox_word(sw4), .new_sbox_word(nsw4), .new_block(nb[2]), .ready(rdy[2]), .done(dn[2]));

   task automatic expand(input int s, input int nk);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) kw[s][i] = KEY[255 - 32*i -: 32];
      for (int i = nk; i < 60; i++) begin
         t = kw[s][i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         kw[s][i] = kw[s][i-nk] ^ t;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One operation on DUT s; optionally re-requests mid-run or holds next through completion.
   task automatic run(input int s, input logic [1:0] k, input logic [127:0] exp_ct,
                      input int exp_lat, input logic [3:0] exp_nr, input int disturb,
                      input bit hold, input string tag);
      int lat;
      int dcnt;
      blk   = PT;
      kl[s] = k;
      nx[s] = 1'b1;
      tick();
      if (!hold) nx[s] = 1'b0;
      chk({tag, " ready_low"}, 128'(rdy[s]), 128'(0));
      lat  = 0;
      dcnt = 0;
      while (rdy[s] !== 1'b1 && lat < 200) begin
         if (lat == disturb) begin
            nx[s] = 1'b1;
            blk   = ~PT;
            kl[s] = 2'b10;
         end
         tick();
         lat++;
         if (!hold) nx[s] = 1'b0;
         if (dn[s] === 1'b1) dcnt++;
      end
      chk({tag, " latency"},   128'(lat),   128'(exp_lat));
      chk({tag, " result"},    nb[s],       exp_ct);
      chk({tag, " done_cnt"},  128'(dcnt),  128'(1));
      chk({tag, " round_no"},  128'(rn[s]), 128'(exp_nr));
      tick();
      chk({tag, " done_clr"},  128'(dn[s]),  128'(0));
      chk({tag, " hold_res"},  nb[s],        exp_ct);
      chk({tag, " idle_rdy"},  128'(rdy[s]), 128'(1));
      chk({tag, " idle_rn"},   128'(rn[s]),  128'(exp_nr));
      if (hold) begin
         tick();
         chk({tag, " restart"}, 128'(rdy[s]), 128'(0));
         nx[s] = 1'b0;
         lat   = 0;
         while (rdy[s] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
         end
         chk({tag, " latency2"}, 128'(lat), 128'(exp_lat));
         chk({tag, " result2"},  nb[s],     exp_ct);
         tick();
      end
   endtask

   initial begin
      int dcnt;
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcnt;
      reset = 1'b0;
      blk   = '0;
      for (int s = 0; s < 3; s++) begin
         nx[s] = 1'b0;
         kl[s] = 2'b00;
`ifdef AES_ENC_ABORT_EN
         ab[s] = 1'b0;
`endif
      end
      expand(0, 4);
      expand(1, 6);
      expand(2, 8);
      #12;
      for (int s = 0; s < 3; s++) begin
         chk("rst ready",     128'(rdy[s]), 128'(1));
         chk("rst done",      128'(dn[s]),  128'(0));
         chk("rst new_block", nb[s],        128'(0));
         chk("rst round_no",  128'(rn[s]),  128'(0));
      end
      chk("rst sbox_word1", 128'(sw1), 128'(0));
      chk("rst sbox_word4", sw4,       128'(0));
      reset = 1'b1;
      tick();

      run(0, 2'b00, CT128, 51, 4'd10, -1, 1'b0, "aes128_l1");
      run(1, 2'b01, CT192, 37, 4'd12, -1, 1'b0, "aes192_l2");
      run(2, 2'b10, CT256, 29, 4'd14, -1, 1'b0, "aes256_l4");
      run(0, 2'b11, CT128, 51, 4'd10, -1, 1'b0, "kl11_l1");
      run(0, 2'b00, CT128, 51, 4'd10,  9, 1'b0, "busy_next");
      run(0, 2'b00, CT128, 51, 4'd10, -1, 1'b1, "next_held");
      chk("idle sbox_word1", 128'(sw1), 128'(0));

      // Asynchronous reset in the middle of an AES-128 run.
      blk   = PT;
      kl[0] = 2'b00;
      nx[0] = 1'b1;
      tick();
      nx[0] = 1'b0;
      repeat (19) tick();
      reset = 1'b0;
      #1;
      chk("midrst ready",     128'(rdy[0]), 128'(1));
      chk("midrst new_block", nb[0],        128'(0));
      chk("midrst round_no",  128'(rn[0]),  128'(0));
      chk("midrst done",      128'(dn[0]),  128'(0));
      #2;
      reset = 1'b1;
      dcnt  = 0;
      repeat (60) begin
         tick();
         if (dn[0] === 1'b1) dcnt++;
      end
      chk("midrst no_done",  128'(dcnt),   128'(0));
      chk("midrst idle_rdy", 128'(rdy[0]), 128'(1));
      run(0, 2'b00, CT128, 51, 4'd10, -1, 1'b0, "after_reset");

`ifdef AES_ENC_ABORT_EN
      blk   = PT;
      kl[0] = 2'b00;
      nx[0] = 1'b1;
      tick();
      nx[0] = 1'b0;
      repeat (29) tick();
      ab[0] = 1'b1;
      tick();
      ab[0] = 1'b0;
      chk("abort ready",     128'(rdy[0]), 128'(1));
      chk("abort new_block", nb[0],        128'(0));
      chk("abort done",      128'(dn[0]),  128'(0));
      run(0, 2'b00, CT128, 51, 4'd10, -1, 1'b0, "after_abort");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
